// File: rtl/poly_matvec_sched.sv
// rtl/poly_matvec_sched.sv - sequences the shared polynomial multiplier through a matrix-vector product
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_l = dimension L, cmd_transpose selects A^T
//   cmd_err                     same-cycle pulse when an offered command has an illegal L
//   abort                       level, requests early termination
//   busy, done, aborted         status; aborted is meaningful only while done is high
//   mul_start, mul_done         multiplier start pulse / completion pulse
//   a_idx, b_idx, c_idx         polynomial selects for the A, s and result banks
//   clr_we, clr_addr            zero-write strobe and word address into result polynomial c_idx
module poly_matvec_sched #(
    parameter int L_MAX = 4,
    parameter int IDX_W = 2,
    parameter int C_AW  = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [IDX_W:0]     cmd_l,
    input  logic               cmd_transpose,
    output logic               cmd_err,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               mul_start,
    input  logic               mul_done,
    output logic [2*IDX_W-1:0] a_idx,
    output logic [IDX_W-1:0]   b_idx,
    output logic [IDX_W-1:0]   c_idx,
    output logic               clr_we,
    output logic [C_AW-1:0]    clr_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0] L_MAX_V = (IDX_W+1)'(L_MAX);

    state_t           state;
    logic [IDX_W:0]   l_reg;
    logic             tr_reg;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             abort_pend;

    logic             l_legal;
    logic             col_last;
    logic             row_last;
    logic             pend_now;

    assign l_legal  = (cmd_l != '0) && (cmd_l <= L_MAX_V);
    assign col_last = ({1'b0, col} == l_reg - 1'b1);
    assign row_last = ({1'b0, row} == l_reg - 1'b1);
    // Outputs are registered, so decisions about the next cycle must also see
    // an abort arriving this cycle, not only the already-latched one.
    assign pend_now = abort_pend || abort;

    assign cmd_err = cmd_valid && cmd_ready && !l_legal;

    // row/col only move on mul_done, so the selects are stable from START to mul_done.
    assign a_idx = tr_reg ? {col, row} : {row, col};
    assign b_idx = col;
    assign c_idx = row;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            l_reg      <= '0;
            tr_reg     <= 1'b0;
            row        <= '0;
            col        <= '0;
            abort_pend <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            mul_start  <= 1'b0;
            clr_we     <= 1'b0;
            clr_addr   <= '0;
        end else begin
            mul_start  <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= (state != S_IDLE) && pend_now;

            case (state)
                S_IDLE: begin
                    if (cmd_valid && l_legal) begin
                        l_reg     <= cmd_l;
                        tr_reg    <= cmd_transpose;
                        row       <= '0;
                        col       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        clr_we    <= 1'b1;
                        clr_addr  <= '0;
                        state     <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (pend_now) begin
                        clr_we   <= 1'b0;
                        clr_addr <= '0;
                        done     <= 1'b1;
                        aborted  <= 1'b1;
                        state    <= S_DONE;
                    end else if (&clr_addr) begin
                        clr_we    <= 1'b0;
                        clr_addr  <= '0;
                        mul_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end

                S_START: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    // Even when aborting, the multiplier is allowed to finish first.
                    if (mul_done) begin
                        if (pend_now) begin
                            done    <= 1'b1;
                            aborted <= 1'b1;
                            state   <= S_DONE;
                        end else if (!col_last) begin
                            col       <= col + 1'b1;
                            mul_start <= 1'b1;
                            state     <= S_START;
                        end else if (!row_last) begin
                            row    <= row + 1'b1;
                            col    <= '0;
                            clr_we <= 1'b1;
                            state  <= S_CLEAR;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    abort_pend <= 1'b0;
                    cmd_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_matvec_sched.sv
// tb/tb_poly_matvec_sched.sv - self-checking bench for poly_matvec_sched
module tb_poly_matvec_sched;

    localparam int IDX_W = 2;
    localparam int C_AW  = 7;
    localparam int NCLR  = 1 << C_AW;
    localparam int NSEL  = 1 << IDX_W;

    logic                clk = 1'b0;
    logic                resetn;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IDX_W:0]      cmd_l;
    logic                cmd_transpose;
    logic                cmd_err;
    logic                abort;
    logic                busy;
    logic                done;
    logic                aborted;
    logic                mul_start;
    logic                mul_done;
    logic [2*IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]    b_idx;
    logic [IDX_W-1:0]    c_idx;
    logic                clr_we;
    logic [C_AW-1:0]     clr_addr;

    poly_matvec_sched #(.L_MAX(4), .IDX_W(IDX_W), .C_AW(C_AW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_l(cmd_l),
        .cmd_transpose(cmd_transpose), .cmd_err(cmd_err), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted),
        .mul_start(mul_start), .mul_done(mul_done),
        .a_idx(a_idx), .b_idx(b_idx), .c_idx(c_idx),
        .clr_we(clr_we), .clr_addr(clr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Multiplier model: mul_done exactly t_mul cycles after each mul_start.
    int   t_mul    = 10;
    int   resp_cnt = -1;
    logic done_auto = 1'b0;
    logic stray     = 1'b0;
    assign mul_done = done_auto | stray;

    always @(negedge clk) begin
        done_auto = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                done_auto = 1'b1;
                resp_cnt  = -1;
            end
        end
        if (mul_start === 1'b1) resp_cnt = t_mul;
    end

    // Observation records.
    int st_a[$], st_b[$], st_c[$], st_cyc[$];
    int clr_len[$], clr_start[$];
    int done_cyc[$];
    bit done_ab[$];
    bit clr_bad = 1'b0;
    bit prev_we = 1'b0;

    always @(negedge clk) begin
        if (mul_start === 1'b1) begin
            st_a.push_back(int'(a_idx));
            st_b.push_back(int'(b_idx));
            st_c.push_back(int'(c_idx));
            st_cyc.push_back(cyc);
        end
        if (clr_we === 1'b1) begin
            if (!prev_we) begin
                clr_len.push_back(0);
                clr_start.push_back(cyc);
            end
            if (int'(clr_addr) != clr_len[clr_len.size()-1]) clr_bad = 1'b1;
            clr_len[clr_len.size()-1] = clr_len[clr_len.size()-1] + 1;
        end
        prev_we = (clr_we === 1'b1);
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_ab.push_back(aborted);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rec();
        st_a.delete(); st_b.delete(); st_c.delete(); st_cyc.delete();
        clr_len.delete(); clr_start.delete();
        done_cyc.delete(); done_ab.delete();
        clr_bad = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({p, "_busy"},      32'(busy), 0);
        chk({p, "_done"},      32'(done), 0);
        chk({p, "_cmd_err"},   32'(cmd_err), 0);
        chk({p, "_aborted"},   32'(aborted), 0);
        chk({p, "_mul_start"}, 32'(mul_start), 0);
        chk({p, "_clr_we"},    32'(clr_we), 0);
        chk({p, "_clr_addr"},  32'(clr_addr), 0);
        chk({p, "_a_idx"},     32'(a_idx), 0);
        chk({p, "_b_idx"},     32'(b_idx), 0);
        chk({p, "_c_idx"},     32'(c_idx), 0);
    endtask

    task automatic issue(input int l, input bit tr, output int acc, output bit err);
        clear_rec();
        cmd_l         = l[IDX_W:0];
        cmd_transpose = tr;
        cmd_valid     = 1'b1;
        acc           = cyc;
        #1;
        err = cmd_err;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int bound);
        int k = 0;
        while (st_cyc.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk("start_wait", st_cyc.size(), n);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done_cyc.size() == 0 && k < bound) begin
            tick();
            k++;
        end
        chk("done_seen", done_cyc.size(), 1);
    endtask

    // Compares a completed, non-aborted command with the reference schedule.
    task automatic check_full(input string p, input int l, input bit tr, input int acc, input int tm);
        int k = 0;
        chk({p, "_n_start"}, st_a.size(), l * l);
        for (int i = 0; i < l; i++) begin
            for (int j = 0; j < l; j++) begin
                int ea;
                ea = tr ? (j * NSEL + i) : (i * NSEL + j);
                if (k < st_a.size()) begin
                    chk({p, "_a_idx"}, st_a[k], ea);
                    chk({p, "_b_idx"}, st_b[k], j);
                    chk({p, "_c_idx"}, st_c[k], i);
                end
                k++;
            end
        end
        chk({p, "_n_clear"}, clr_len.size(), l);
        foreach (clr_len[q]) chk({p, "_clear_len"}, clr_len[q], NCLR);
        chk({p, "_clr_addr_seq"}, 32'(clr_bad), 0);
        if (clr_start.size() > 0) chk({p, "_first_clr"}, clr_start[0], acc + 1);
        if (st_cyc.size() > 0) chk({p, "_first_start"}, st_cyc[0], acc + 1 + NCLR);
        if (done_cyc.size() > 0) begin
            chk({p, "_total"}, done_cyc[0] - acc + 1, l * NCLR + l * l * (tm + 1) + 2);
            chk({p, "_aborted"}, 32'(done_ab[0]), 0);
        end
    endtask

    task automatic after_done(input string p);
        tick();
        chk({p, "_ready_after"}, 32'(cmd_ready), 1);
        chk({p, "_busy_after"},  32'(busy), 0);
        chk({p, "_done_once"},   done_cyc.size(), 1);
    endtask

    function automatic int bound_for(input int l, input int tm);
        return l * NCLR + l * l * (tm + 1) + 40;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit err;
        int l;
        bit tr;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_l = '0; cmd_transpose = 1'b0; abort = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        resetn = 1'b1;
        tick();

        // L=3 direct
        t_mul = 10;
        issue(3, 1'b0, acc, err);
        chk("l3_err", 32'(err), 0);
        wait_done(bound_for(3, t_mul));
        check_full("l3", 3, 1'b0, acc, t_mul);
        after_done("l3");

        // L=2 transposed
        t_mul = $urandom_range(1, 12);
        issue(2, 1'b1, acc, err);
        wait_done(bound_for(2, t_mul));
        check_full("l2t", 2, 1'b1, acc, t_mul);
        after_done("l2t");

        // Illegal dimensions
        issue(0, 1'b0, acc, err);
        chk("l0_err", 32'(err), 1);
        chk("l0_busy", 32'(busy), 0);
        tick();
        chk("l0_err_pulse", 32'(cmd_err), 0);
        chk("l0_no_clear", 32'(clr_we), 0);
        issue(5, 1'b0, acc, err);
        chk("l5_err", 32'(err), 1);
        chk("l5_busy", 32'(busy), 0);
        tick();
        chk("l5_busy2", 32'(busy), 0);
        t_mul = 4;
        issue(1, 1'b0, acc, err);
        chk("l1_err", 32'(err), 0);
        wait_done(bound_for(1, t_mul));
        check_full("l1", 1, 1'b0, acc, t_mul);
        after_done("l1");

        // Random back-to-back commands, each accepted the cycle after the previous done.
        for (int r = 0; r < 6; r++) begin
            l     = $urandom_range(1, 4);
            tr    = 1'($urandom_range(0, 1));
            t_mul = $urandom_range(1, 12);
            issue(l, tr, acc, err);
            wait_done(bound_for(l, t_mul));
            check_full("rnd", l, tr, acc, t_mul);
            after_done("rnd");
        end

        // Abort during the second product
        t_mul = 10;
        issue(3, 1'b0, acc, err);
        wait_starts(2, 3 * NCLR);
        repeat (3) tick();
        abort = 1'b1;
        wait_done(40);
        abort = 1'b0;
        chk("abt_n_start", st_a.size(), 2);
        if (done_cyc.size() > 0 && st_cyc.size() > 1) begin
            chk("abt_latency", done_cyc[0], st_cyc[1] + t_mul + 1);
            chk("abt_flag", 32'(done_ab[0]), 1);
        end
        repeat (20) tick();
        chk("abt_no_more_start", st_a.size(), 2);
        chk("abt_idle", 32'(cmd_ready), 1);

        // Abort coinciding with the final mul_done
        t_mul = 5;
        issue(1, 1'b0, acc, err);
        wait_starts(1, 2 * NCLR);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(10);
        if (done_ab.size() > 0) chk("abt_last_flag", 32'(done_ab[0]), 1);
        after_done("abt_last");

        // Reset during WAIT
        t_mul = 10;
        issue(2, 1'b0, acc, err);
        wait_starts(1, 2 * NCLR);
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        chk_reset("wrst");
        resetn = 1'b1;
        repeat (12) tick();
        chk("wrst_busy", 32'(busy), 0);
        chk("wrst_n_start", st_a.size(), 1);
        chk("wrst_no_done", done_cyc.size(), 0);
        t_mul = $urandom_range(1, 12);
        issue(2, 1'b0, acc, err);
        wait_done(bound_for(2, t_mul));
        check_full("wrst_new", 2, 1'b0, acc, t_mul);
        after_done("wrst_new");

        // Stray mul_done in IDLE and CLEAR
        t_mul = 7;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_idle_busy", 32'(busy), 0);
        issue(2, 1'b1, acc, err);
        repeat (10) tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        wait_done(bound_for(2, t_mul));
        check_full("stray", 2, 1'b1, acc, t_mul);
        after_done("stray");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
